// File: rtl/gpu_out_fifo_if.sv
// Host-side drain stream of the GPU output FIFO.
// First-word-fall-through head with valid/ready handshake.
interface gpu_out_fifo_if #(
   parameter int data_width = 32
);
   logic                  out_valid;
   logic                  out_ready;
   logic [data_width-1:0] out_data;
   logic                  out_is_float;

   modport master (
      output out_valid,
      output out_data,
      output out_is_float,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_is_float,
      output out_ready
   );
endinterface

// File: rtl/gpu_out_fifo.sv
// Buffers the core's print/debug output stream for the host and
// reports a drained halt once every pre-halt word has been popped.
module gpu_out_fifo #(
   parameter int data_width = 32,
   parameter int depth      = 16,
   parameter int drop_width = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    in_en,
   input  logic                    in_flen,
   input  logic [data_width-1:0]   in_data,
   input  logic                    core_halt,
   gpu_out_fifo_if.master          out_if,
   output logic [$clog2(depth):0]  count,
   output logic                    overflow,
   output logic [drop_width-1:0]   drop_count,
   output logic                    halt_done
);

   localparam int aw = $clog2(depth);
   localparam int cw = aw + 1;
   localparam logic [cw-1:0] full_cnt = cw'(depth);

   typedef enum logic [1:0] {
      H_IDLE,
      H_PEND,
      H_DONE
   } halt_t;

   logic [data_width:0] mem [depth];
   logic [aw-1:0]       wr_ptr;
   logic [aw-1:0]       rd_ptr;
   logic [cw-1:0]       count_nxt;
   logic                wclr;
   logic                pop;
   logic                push;
   logic                drop;
   halt_t               state;
   halt_t               state_nxt;

   assign wclr = rst | clr;
   assign pop  = out_if.out_valid & out_if.out_ready;
   assign push = in_en & ((count < full_cnt) | pop);
   assign drop = in_en & ~push;

   assign out_if.out_valid = (count != '0);
   assign {out_if.out_is_float, out_if.out_data} = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + 1'b1;
      else if (pop && !push)
         count_nxt = count - 1'b1;
   end

   // Storage is never cleared; pointers and count define what is live.
   always_ff @(posedge clk) begin
      if (push && !wclr)
         mem[wr_ptr] <= {in_flen, in_data};
   end

   always_ff @(posedge clk) begin
      if (wclr) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1)
               drop_count <= drop_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wclr)
         state <= H_IDLE;
      else
         state <= state_nxt;
   end

   // An already-empty FIFO goes straight to DONE so halt_done
   // follows core_halt by a single cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         H_IDLE: begin
            if (core_halt)
               state_nxt = (count_nxt == '0) ? H_DONE : H_PEND;
         end
         H_PEND: begin
            if (!core_halt)
               state_nxt = H_IDLE;
            else if (count_nxt == '0)
               state_nxt = H_DONE;
         end
         H_DONE: begin
            if (!core_halt)
               state_nxt = H_IDLE;
            else if (count_nxt != '0)
               state_nxt = H_PEND;
         end
         default: state_nxt = H_IDLE;
      endcase
   end

   assign halt_done = (state == H_DONE);

endmodule

// File: tb/tb_gpu_out_fifo.sv
// Directed-vector bench for gpu_out_fifo.
// Expected values are hand-computed per scenario.
module tb_gpu_out_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        in_en;
   logic        in_flen;
   logic [31:0] in_data;
   logic        core_halt;
   logic [4:0]  count;
   logic        overflow;
   logic [15:0] drop_count;
   logic        halt_done;

   int vec_cnt = 0;
   int mis_cnt = 0;

   gpu_out_fifo_if #(.data_width(32)) host ();

   gpu_out_fifo #(
      .data_width(32),
      .depth(16),
      .drop_width(16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_en     (in_en),
      .in_flen   (in_flen),
      .in_data   (in_data),
      .core_halt (core_halt),
      .out_if    (host.master),
      .count     (count),
      .overflow  (overflow),
      .drop_count(drop_count),
      .halt_done (halt_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         mis_cnt++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      in_en = 1'b0;
      in_flen = 1'b0;
      in_data = '0;
      core_halt = 1'b0;
      host.out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("rst_count", 64'(count), 0);
      chk("rst_valid", 64'(host.out_valid), 0);
      chk("rst_ovf", 64'(overflow), 0);
      chk("rst_drop", 64'(drop_count), 0);
      chk("rst_halt", 64'(halt_done), 0);

      // 1: three words, then drain in order
      in_en = 1'b1;
      in_data = 32'h11; in_flen = 1'b0; step();
      in_data = 32'h22; in_flen = 1'b1; step();
      in_data = 32'h33; in_flen = 1'b0; step();
      in_en = 1'b0;
      chk("t1_count", 64'(count), 3);
      chk("t1_valid", 64'(host.out_valid), 1);
      host.out_ready = 1'b1;
      chk("t1_d0", 64'(host.out_data), 64'h11);
      chk("t1_f0", 64'(host.out_is_float), 0);
      step();
      chk("t1_d1", 64'(host.out_data), 64'h22);
      chk("t1_f1", 64'(host.out_is_float), 1);
      step();
      chk("t1_d2", 64'(host.out_data), 64'h33);
      chk("t1_f2", 64'(host.out_is_float), 0);
      step();
      chk("t1_empty", 64'(host.out_valid), 0);
      chk("t1_count0", 64'(count), 0);
      host.out_ready = 1'b0;

      // 2: fill, then two drops
      in_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data = 32'h100 + 32'(i);
         in_flen = i[0];
         step();
      end
      in_data = 32'hdead; step();
      in_data = 32'hbeef; step();
      in_en = 1'b0;
      chk("t2_count", 64'(count), 16);
      chk("t2_ovf", 64'(overflow), 1);
      chk("t2_drop", 64'(drop_count), 2);
      chk("t2_head", 64'(host.out_data), 64'h100);

      // 3: full with simultaneous push and pop
      in_en = 1'b1;
      in_data = 32'h999;
      in_flen = 1'b1;
      host.out_ready = 1'b1;
      step();
      in_en = 1'b0;
      chk("t3_count", 64'(count), 16);
      chk("t3_drop", 64'(drop_count), 2);
      chk("t3_head", 64'(host.out_data), 64'h101);
      for (int i = 1; i < 16; i++) begin
         chk("t3_order", 64'(host.out_data), 64'h100 + 64'(i));
         step();
      end
      chk("t3_tail", 64'(host.out_data), 64'h999);
      chk("t3_tailf", 64'(host.out_is_float), 1);
      step();
      chk("t3_empty", 64'(count), 0);
      chk("t3_sticky", 64'(overflow), 1);
      clr = 1'b1; step(); clr = 1'b0;

      // 4: streaming through with pointer wrap
      in_en = 1'b1;
      in_flen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         in_data = 32'h2000 + 32'(k);
         step();
         chk("t4_data", 64'(host.out_data), 64'h2000 + 64'(k));
         chk("t4_count", 64'(count), 1);
      end
      in_en = 1'b0;
      step();
      chk("t4_empty", 64'(count), 0);
      chk("t4_nodrop", 64'(drop_count), 0);
      chk("t4_noovf", 64'(overflow), 0);

      // 5: drained halt
      host.out_ready = 1'b0;
      in_en = 1'b1;
      in_data = 32'h51; step();
      in_data = 32'h52; step();
      in_en = 1'b0;
      core_halt = 1'b1;
      step();
      chk("t5_pend0", 64'(halt_done), 0);
      step();
      chk("t5_pend1", 64'(halt_done), 0);
      host.out_ready = 1'b1;
      step();
      chk("t5_pop1", 64'(halt_done), 0);
      chk("t5_cnt1", 64'(count), 1);
      step();
      chk("t5_done", 64'(halt_done), 1);
      chk("t5_cnt0", 64'(count), 0);
      core_halt = 1'b0;
      step();
      chk("t5_restart", 64'(halt_done), 0);
      core_halt = 1'b1;
      step();
      chk("t5_empty_halt", 64'(halt_done), 1);
      host.out_ready = 1'b0;
      in_en = 1'b1;
      in_data = 32'h53;
      step();
      in_en = 1'b0;
      chk("t5_repend", 64'(halt_done), 0);
      chk("t5_repcnt", 64'(count), 1);
      host.out_ready = 1'b1;
      step();
      chk("t5_redone", 64'(halt_done), 1);
      core_halt = 1'b0;
      host.out_ready = 1'b0;
      step();
      chk("t5_idle", 64'(halt_done), 0);

      // 6: clear while half full with concurrent push/pop
      in_en = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_data = 32'h600 + 32'(i);
         step();
      end
      in_en = 1'b0;
      host.out_ready = 1'b1;
      for (int i = 0; i < 8; i++)
         step();
      host.out_ready = 1'b0;
      chk("t6_half", 64'(count), 8);
      chk("t6_ovf", 64'(overflow), 1);
      chk("t6_drop", 64'(drop_count), 1);
      clr = 1'b1;
      in_en = 1'b1;
      host.out_ready = 1'b1;
      step();
      clr = 1'b0;
      in_en = 1'b0;
      chk("t6_count", 64'(count), 0);
      chk("t6_valid", 64'(host.out_valid), 0);
      chk("t6_ovf0", 64'(overflow), 0);
      chk("t6_drop0", 64'(drop_count), 0);
      step();
      chk("t6_underflow", 64'(count), 0);
      in_en = 1'b1;
      in_data = 32'h777;
      host.out_ready = 1'b0;
      step();
      in_en = 1'b0;
      chk("t6_restart", 64'(host.out_data), 64'h777);
      chk("t6_recount", 64'(count), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
      $finish;
   end

endmodule
